// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, grant codes
// and default starvation parameters.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_LOCK    = 2'd1,
        S_RELEASE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_C    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 3;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating wait counter for the debug port; freeze has priority over clear,
// clear over increment.
module dmem_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic frz,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!frz) begin
            if (clr)
                cnt_d = '0;
            else if (inc && cnt_q != LIM)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the pipeline MEM stage (C) and a debug/loader
// master (D), with starvation pre-emption and a D-owned lock mode.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dm_w,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    arb_state_e        state_d, state_q;
    gnt_e              gnt;
    logic              at_limit;
    logic              rvalid_d, rvalid_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb begin
        gnt     = GNT_NONE;
        state_d = state_q;
        case (state_q)
            S_CPU: begin
                if (dbg_valid && at_limit) gnt = GNT_D;
                else if (cpu_req)          gnt = GNT_C;
                else if (dbg_valid)        gnt = GNT_D;
                if (gnt == GNT_D && dbg_lock) state_d = S_LOCK;
            end
            S_LOCK: begin
                // a pending request is still served in the cycle the lock drops
                if (dbg_valid) gnt = GNT_D;
                if (!dbg_lock) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (cpu_req) gnt = GNT_C;
                state_d = S_CPU;
            end
            default: state_d = S_CPU;
        endcase
        if (!rst) gnt = GNT_NONE;
    end

    always_comb begin
        dm_w     = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        case (gnt)
            GNT_C: begin
                dm_w     = cpu_we;
                dm_addr  = cpu_addr;
                dm_wdata = cpu_wdata;
            end
            GNT_D: begin
                dm_w     = dbg_we;
                dm_addr  = dbg_addr;
                dm_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    assign dbg_ready = (gnt == GNT_D);
    assign cpu_stall = rst && cpu_req && (gnt != GNT_C);
    assign cpu_rdata = dm_rdata;

    dmem_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr      ((gnt == GNT_D) || !dbg_valid),
        .inc      (1'b1),
        .frz      (state_q == S_LOCK),
        .at_limit (at_limit)
    );

    always_comb begin
        rvalid_d = (gnt == GNT_D) && !dbg_we;
        rdata_d  = rvalid_d ? dm_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_CPU;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle expectations and
// read responses; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    logic        clk, rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_ready, dbg_we, dbg_lock, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dm_w;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) if (dm_w) mem[dm_addr[7:2]] <= dm_wdata;

    typedef struct {
        int          tag;
        logic        rdy, stl, w;
        logic [31:0] addr, wd;
        logic        rv;
        logic [31:0] hold;
        bit          cchk;
        logic [31:0] crd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd;
    bit          chk_crd;
    logic [31:0] exp_crd;
    int          checks, failures;

    task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL t%0d %s actual=%h expected=%h", tag, nm, act, exp);
        end
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m = exp_q.pop_front();
            chk(m.tag, "dbg_ready",  {31'd0, dbg_ready},  {31'd0, m.rdy});
            chk(m.tag, "cpu_stall",  {31'd0, cpu_stall},  {31'd0, m.stl});
            chk(m.tag, "dm_w",       {31'd0, dm_w},       {31'd0, m.w});
            chk(m.tag, "dm_addr",    dm_addr,             m.addr);
            chk(m.tag, "dm_wdata",   dm_wdata,            m.wd);
            chk(m.tag, "dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m.rv});
            if (!m.rv) chk(m.tag, "dbg_rdata_hold", dbg_rdata, m.hold);
            if (m.cchk) chk(m.tag, "cpu_rdata", cpu_rdata, m.crd);
        end
        if (dbg_rvalid) begin
            if (rd_q.size() != 0) chk(-1, "dbg_rdata", dbg_rdata, rd_q.pop_front());
            else begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual=1 expected=0");
            end
        end
    end

    task automatic cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
        dbg_valid = v; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lk;
    endtask

    // push expectation for the current cycle, then advance to posedge+1
    task automatic cyc(input int tag, input logic rdy, input logic stl, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic rv);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.stl = stl; e.w = w; e.addr = a; e.wd = d;
        e.rv = rv; e.hold = last_rd; e.cchk = chk_crd; e.crd = exp_crd;
        exp_q.push_back(e);
        chk_crd = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int tag, input logic rv);
        cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);
        cyc(tag, 0, 0, 0, 0, 0, rv);
    endtask

    initial begin
        checks = 0; failures = 0; last_rd = '0; chk_crd = 1'b0; exp_crd = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst = 1'b0;
        cpu(1, 1, 32'h4, 32'h99); dbg(1, 1, 32'h8, 32'h77, 1);
        @(posedge clk); #1;
        // reset forces everything idle even with live requests
        cyc(0, 0, 0, 0, 0, 0, 0);

        // D write then read-back
        rst = 1'b1;
        cpu(0, 0, 0, 0); dbg(1, 1, 32'h10, 32'h12345678, 0);
        cyc(1, 1, 0, 1, 32'h10, 32'h12345678, 0);
        dbg(1, 0, 32'h10, 32'h0, 0);
        rd_q.push_back(32'h12345678);
        cyc(2, 1, 0, 0, 32'h10, 32'h0, 0);
        idle(3, 1);
        last_rd = 32'h12345678;

        // starvation pre-emption over 10 cpu_req cycles
        cpu(1, 0, 32'h40, 0); dbg(1, 1, 32'h44, 32'hAA, 0);
        for (int i = 0; i < 4; i++) cyc(10 + i, 0, 0, 0, 32'h40, 0, 0);
        cyc(14, 1, 1, 1, 32'h44, 32'hAA, 0);
        dbg(1, 1, 32'h48, 32'hBB, 0);
        for (int i = 0; i < 4; i++) cyc(15 + i, 0, 0, 0, 32'h40, 0, 0);
        cyc(19, 1, 1, 1, 32'h48, 32'hBB, 0);
        idle(20, 0);

        // lock burst, release cycle goes to C even with D pending
        cpu(0, 0, 32'h40, 0); dbg(1, 1, 32'h20, 32'h200, 1);
        cyc(30, 1, 0, 1, 32'h20, 32'h200, 0);
        cpu(1, 0, 32'h40, 0); dbg(1, 1, 32'h24, 32'h240, 1);
        cyc(31, 1, 1, 1, 32'h24, 32'h240, 0);
        dbg(1, 1, 32'h28, 32'h280, 1);
        cyc(32, 1, 1, 1, 32'h28, 32'h280, 0);
        dbg(0, 0, 0, 0, 1);
        cyc(33, 0, 1, 0, 0, 0, 0);
        dbg(1, 1, 32'h2C, 32'h2C0, 0);
        cyc(34, 1, 1, 1, 32'h2C, 32'h2C0, 0);
        dbg(1, 1, 32'h38, 32'h380, 0);
        cyc(35, 0, 0, 0, 32'h40, 0, 0);
        cpu(0, 0, 0, 0);
        cyc(36, 1, 0, 1, 32'h38, 32'h380, 0);
        idle(37, 0);

        // same address collision: C store first, D reads new value
        cpu(1, 1, 32'h30, 32'h00C0FFEE); dbg(1, 0, 32'h30, 0, 0);
        cyc(40, 0, 0, 1, 32'h30, 32'h00C0FFEE, 0);
        cpu(0, 0, 0, 0);
        rd_q.push_back(32'h00C0FFEE);
        cyc(41, 1, 0, 0, 32'h30, 0, 0);
        idle(42, 1);
        last_rd = 32'h00C0FFEE;

        // reset during lock drops the in-flight read
        dbg(1, 1, 32'h50, 32'h5, 1);
        cyc(50, 1, 0, 1, 32'h50, 32'h5, 0);
        cpu(1, 0, 32'h10, 0); dbg(1, 0, 32'h10, 0, 1);
        cyc(51, 1, 1, 0, 32'h10, 0, 0);
        rst = 1'b0;
        last_rd = '0;
        cyc(52, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        dbg(0, 0, 0, 0, 0);
        chk_crd = 1'b1; exp_crd = 32'h12345678;
        cyc(53, 0, 0, 0, 32'h10, 0, 0);
        idle(54, 0);

        // counter clears when dbg_valid drops after 3 waits
        cpu(1, 0, 32'h40, 0); dbg(1, 1, 32'h60, 32'h6, 0);
        for (int i = 0; i < 3; i++) cyc(60 + i, 0, 0, 0, 32'h40, 0, 0);
        dbg(0, 1, 32'h60, 32'h6, 0);
        cyc(63, 0, 0, 0, 32'h40, 0, 0);
        dbg(1, 1, 32'h60, 32'h6, 0);
        for (int i = 0; i < 4; i++) cyc(64 + i, 0, 0, 0, 32'h40, 0, 0);
        cyc(68, 1, 1, 1, 32'h60, 32'h6, 0);
        idle(69, 0);
        idle(70, 0);

        checks++;
        if (rd_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d expected=0/0", rd_q.size(), exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
